// File: rtl/ir_cam_pkg.sv
// Shared constants, blob payload type and report-decode helper for the IR camera decoder.
package ir_cam_pkg;

    localparam int unsigned PKT_BYTES      = 13;
    localparam int unsigned BYTES_PER_BLOB = 3;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned COORD_W        = 10;
    localparam int unsigned SIZE_W         = 4;
    localparam int unsigned ERR_W          = 8;

    localparam logic [COORD_W-1:0] NO_BLOB = 10'd1023;
    localparam logic [SIZE_W-1:0]  NO_SIZE = 4'hF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  size;
    } blob_t;

    localparam blob_t NO_BLOB_T = '{x: NO_BLOB, y: NO_BLOB, size: NO_SIZE};

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } rx_state_e;

    // Unpack one 3-byte extended-mode blob; an absent slot (all 0xFF) decodes to no-blob.
    function automatic blob_t decode_blob(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic       flip);
        blob_t              blob;
        logic [COORD_W-1:0] x_raw;
        x_raw     = {b2[5:4], b0};
        blob.x    = (flip && (x_raw != NO_BLOB)) ? (NO_BLOB - x_raw) : x_raw;
        blob.y    = {b2[7:6], b1};
        blob.size = b2[3:0];
        return blob;
    endfunction

endpackage

// File: rtl/ir_packet_decoder_if.sv
// Byte-stream input and decoded-blob output bundle of the IR packet decoder.
interface ir_packet_decoder_if;
    import ir_cam_pkg::*;

    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               sof;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SIZE_W-1:0]  size;
    logic               xy_valid;
    logic               stale;
    logic [ERR_W-1:0]   err_count;

    modport master (
        output byte_in, byte_valid, sof,
        input  x, y, size, xy_valid, stale, err_count
    );

    modport slave (
        input  byte_in, byte_valid, sof,
        output x, y, size, xy_valid, stale, err_count
    );

endinterface

// File: rtl/stale_timer.sv
// Saturating watchdog counter; o_expire_c flags the cycle whose edge brings the count to TIMEOUT_CYCLES-1.
module stale_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Look one count ahead so the forced no-blob lands on the same edge the count reaches its limit.
    assign o_expire_c = !i_clear && (r_cnt >= CNT_PRE);

endmodule

// File: rtl/ir_packet_decoder.sv
// Frames 13-byte IR camera reports, decodes one blob slot and forces no-blob when reports go stale.
module ir_packet_decoder
    import ir_cam_pkg::*;
#(
    parameter int unsigned BLOB_SEL       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter bit          FLIP_X         = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    ir_packet_decoder_if.slave bus
);

    localparam logic [IDX_W-1:0] CAP_LO   = IDX_W'(1 + BYTES_PER_BLOB * BLOB_SEL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

    rx_state_e                          r_state, w_state_nxt;
    logic [IDX_W-1:0]                   r_idx, w_idx_nxt;
    logic [BYTES_PER_BLOB-1:0][7:0]     r_cap, w_cap_nxt;
    logic                               r_commit, w_commit_nxt;
    logic [ERR_W-1:0]                   r_err, w_err_nxt;

    blob_t                              r_blob;
    blob_t                              w_blob;
    logic                               r_xy_valid;
    logic                               r_stale;
    logic                               w_expire_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cap    <= '0;
            r_commit <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cap    <= w_cap_nxt;
            r_commit <= w_commit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Framing: sof restarts a report from any state; a restart mid-report counts as a truncation.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cap_nxt    = r_cap;
        w_commit_nxt = 1'b0;
        w_err_nxt    = r_err;
        if (bus.byte_valid) begin
            if (bus.sof) begin
                if ((r_state == RX) && (r_err != '1)) begin
                    w_err_nxt = r_err + ERR_W'(1);
                end
                w_state_nxt = RX;
                w_idx_nxt   = IDX_W'(1);
            end else if (r_state == RX) begin
                for (int unsigned k = 0; k < BYTES_PER_BLOB; k++) begin
                    if (r_idx == (CAP_LO + IDX_W'(k))) begin
                        w_cap_nxt[k] = bus.byte_in;
                    end
                end
                if (r_idx == LAST_IDX) begin
                    w_state_nxt  = IDLE;
                    w_idx_nxt    = '0;
                    w_commit_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign w_blob = decode_blob(r_cap[0], r_cap[1], r_cap[2], FLIP_X);

    stale_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stale_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (r_commit),
        .o_expire_c (w_expire_c)
    );

    // Output stage: a commit always beats a watchdog expiry landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blob     <= NO_BLOB_T;
            r_xy_valid <= 1'b0;
            r_stale    <= 1'b1;
        end else begin
            r_xy_valid <= r_commit;
            if (r_commit) begin
                r_blob  <= w_blob;
                r_stale <= 1'b0;
            end else if (w_expire_c) begin
                r_blob  <= NO_BLOB_T;
                r_stale <= 1'b1;
            end
        end
    end

    assign bus.x         = r_blob.x;
    assign bus.y         = r_blob.y;
    assign bus.size      = r_blob.size;
    assign bus.xy_valid  = r_xy_valid;
    assign bus.stale     = r_stale;
    assign bus.err_count = r_err;

endmodule
